// File: rtl/vga_pkg.sv
// Shared VGA grid geometry defaults, colour codes and cell-validity helper
// used by the ship renderers.
package vga_pkg;

  localparam int GRID_DEF     = 8;
  localparam int ORIGIN_X_DEF = 16;
  localparam int ORIGIN_Y_DEF = 16;
  localparam int STEP_X_DEF   = 62;
  localparam int STEP_Y_DEF   = 57;
  localparam int CELL_W_DEF   = 54;
  localparam int CELL_H_DEF   = 49;

  typedef enum logic [2:0] {
    PRETO    = 3'b000,
    AZUL     = 3'b001,
    VERMELHO = 3'b100,
    AMARELO  = 3'b110
  } cor_t;

  function automatic logic celulaValida(input logic [3:0] x, input logic [3:0] y,
                                        input int grid);
    return (x >= 4'd1) && (int'(x) <= grid) && (y >= 4'd1) && (int'(y) <= grid);
  endfunction

endpackage

// File: rtl/vga_celula_hit.sv
// One ship cell: registered pixel box from grid coordinates plus the strict
// inside test against the current pixel.
module vga_celula_hit
  import vga_pkg::*;
#(
  parameter int GRID     = GRID_DEF,
  parameter int ORIGIN_X = ORIGIN_X_DEF,
  parameter int ORIGIN_Y = ORIGIN_Y_DEF,
  parameter int STEP_X   = STEP_X_DEF,
  parameter int STEP_Y   = STEP_Y_DEF,
  parameter int CELL_W   = CELL_W_DEF,
  parameter int CELL_H   = CELL_H_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] posX,
  input  logic [3:0] posY,
  input  logic [9:0] coluna,
  input  logic [9:0] linha,
  output logic       dentro
);

  logic        valido;
  logic        validoNext;
  logic [10:0] left;
  logic [10:0] top;
  logic [10:0] leftNext;
  logic [10:0] topNext;
  logic [10:0] col11;
  logic [10:0] lin11;

  // Invalid cells keep a zero box so the (X-1) term never underflows.
  always_comb begin
    validoNext = celulaValida(posX, posY, GRID);
    leftNext   = '0;
    topNext    = '0;
    if (validoNext) begin
      leftNext = 11'(ORIGIN_X) + 11'(STEP_X) * (11'(posX) - 11'd1);
      topNext  = 11'(ORIGIN_Y) + 11'(STEP_Y) * (11'(posY) - 11'd1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valido <= 1'b0;
      left   <= '0;
      top    <= '0;
    end else begin
      valido <= validoNext;
      left   <= leftNext;
      top    <= topNext;
    end
  end

  assign col11 = {1'b0, coluna};
  assign lin11 = {1'b0, linha};

  assign dentro = valido
                  && (col11 > left) && (col11 < left + 11'(CELL_W))
                  && (lin11 > top)  && (lin11 < top + 11'(CELL_H));

endmodule

// File: rtl/vga_embarcacao_render.sv
// Ship renderer: frame-shadowed cell coordinates and hits, two-stage pixel
// pipeline, blink timer and sunk detection for a ship of NUM_CELULAS cells.
module vga_embarcacao_render
  import vga_pkg::*;
#(
  parameter int NUM_CELULAS  = 5,
  parameter int GRID         = GRID_DEF,
  parameter int ORIGIN_X     = ORIGIN_X_DEF,
  parameter int ORIGIN_Y     = ORIGIN_Y_DEF,
  parameter int STEP_X       = STEP_X_DEF,
  parameter int STEP_Y       = STEP_Y_DEF,
  parameter int CELL_W       = CELL_W_DEF,
  parameter int CELL_H       = CELL_H_DEF,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     areaAtiva,
  input  logic [9:0]               coluna,
  input  logic [9:0]               linha,
  input  logic                     frame_start,
  input  logic [8*NUM_CELULAS-1:0] posicoesEmbarcacao,
  input  logic [NUM_CELULAS-1:0]   acertos,
  input  logic                     visivel,
  output logic                     rgb_r,
  output logic                     rgb_g,
  output logic                     rgb_b,
  output logic                     afundado
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [8*NUM_CELULAS-1:0] posShadow;
  logic [NUM_CELULAS-1:0]   hitShadow;
  logic                     visShadow;

  logic [NUM_CELULAS-1:0]   dentro;
  logic [NUM_CELULAS-1:0]   validMask;
  logic                     todosAtingidos;
  logic                     fsDly;

  logic [BW-1:0]            blinkCnt;
  logic                     blinkPhase;

  logic                     s1Ativa;
  logic                     s1Vis;
  logic                     s1Phase;
  logic [NUM_CELULAS-1:0]   s1InHit;
  logic [NUM_CELULAS-1:0]   s1InFree;

  cor_t                     corNext;
  logic [2:0]               rgbQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      posShadow <= '0;
      hitShadow <= '0;
      visShadow <= 1'b0;
      fsDly     <= 1'b0;
    end else begin
      fsDly <= frame_start;
      if (frame_start) begin
        posShadow <= posicoesEmbarcacao;
        hitShadow <= acertos;
        visShadow <= visivel;
      end
    end
  end

  for (genvar k = 0; k < NUM_CELULAS; k++) begin : gCelula
    vga_celula_hit #(
      .GRID     (GRID),
      .ORIGIN_X (ORIGIN_X),
      .ORIGIN_Y (ORIGIN_Y),
      .STEP_X   (STEP_X),
      .STEP_Y   (STEP_Y),
      .CELL_W   (CELL_W),
      .CELL_H   (CELL_H)
    ) uCelula (
      .clk    (clk),
      .rst    (rst),
      .posX   (posShadow[8*k +: 4]),
      .posY   (posShadow[8*k+4 +: 4]),
      .coluna (coluna),
      .linha  (linha),
      .dentro (dentro[k])
    );
  end

  // Sunk detection reads the shadow directly so it settles one cycle after capture.
  always_comb begin
    validMask = '0;
    for (int k = 0; k < NUM_CELULAS; k++) begin
      validMask[k] = celulaValida(posShadow[8*k +: 4], posShadow[8*k+4 +: 4], GRID);
    end
    todosAtingidos = (|validMask) && ((validMask & ~hitShadow) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      afundado <= 1'b0;
    end else if (fsDly) begin
      afundado <= todosAtingidos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
    end else if (frame_start) begin
      if (blinkCnt == BW'(BLINK_FRAMES - 1)) begin
        blinkCnt   <= '0;
        blinkPhase <= ~blinkPhase;
      end else begin
        blinkCnt <= blinkCnt + 1'b1;
      end
    end
  end

  // Hit split, visibility and phase are latched with the pixel so a pixel
  // coinciding with frame_start renders entirely from the old frame's state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Ativa  <= 1'b0;
      s1Vis    <= 1'b0;
      s1Phase  <= 1'b0;
      s1InHit  <= '0;
      s1InFree <= '0;
    end else begin
      s1Ativa  <= areaAtiva;
      s1Vis    <= visShadow;
      s1Phase  <= blinkPhase;
      s1InHit  <= dentro & hitShadow;
      s1InFree <= dentro & ~hitShadow;
    end
  end

  always_comb begin
    corNext = PRETO;
    if (!s1Ativa) begin
      corNext = PRETO;
    end else if (afundado && (|(s1InHit | s1InFree))) begin
      corNext = VERMELHO;
    end else if (!s1Vis) begin
      corNext = PRETO;
    end else if (|s1InHit) begin
      corNext = s1Phase ? VERMELHO : AMARELO;
    end else if (|s1InFree) begin
      corNext = AZUL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgbQ <= 3'b000;
    end else begin
      rgbQ <= corNext;
    end
  end

  assign rgb_r = rgbQ[2];
  assign rgb_g = rgbQ[1];
  assign rgb_b = rgbQ[0];

endmodule

// File: tb/tb_vga_embarcacao_render.sv
// Self-checking bench for vga_embarcacao_render: fixed vectors, hand-written
// frame sequences and randomized pixels against a geometric reference model.
module tb_vga_embarcacao_render;

  localparam int N = 5;
  localparam int B = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           areaAtiva;
  logic [9:0]     coluna;
  logic [9:0]     linha;
  logic           frame_start;
  logic [8*N-1:0] posicoesEmbarcacao;
  logic [N-1:0]   acertos;
  logic           visivel;
  logic           rgb_r, rgb_g, rgb_b;
  logic           afundado;

  int checks = 0;
  int errors = 0;

  // Reference state: what the design should have captured at the last frame_start.
  logic [8*N-1:0] mPos;
  logic [N-1:0]   mHit;
  logic           mVis;
  int             mPulses;
  logic           mAfund;

  typedef struct {
    int         x;
    int         y;
    logic       ativa;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[8];

  vga_embarcacao_render #(
    .NUM_CELULAS  (N),
    .BLINK_FRAMES (B)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .areaAtiva          (areaAtiva),
    .coluna             (coluna),
    .linha              (linha),
    .frame_start        (frame_start),
    .posicoesEmbarcacao (posicoesEmbarcacao),
    .acertos            (acertos),
    .visivel            (visivel),
    .rgb_r              (rgb_r),
    .rgb_g              (rgb_g),
    .rgb_b              (rgb_b),
    .afundado           (afundado)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] cel(input int x, input int y);
    logic [3:0] xs;
    logic [3:0] ys;
    xs = x[3:0];
    ys = y[3:0];
    return {ys, xs};
  endfunction

  function automatic logic [2:0] expRgb(input int x, input int y, input logic ativa);
    logic inAny;
    logic inHit;
    int cx, cy, l, t;
    inAny = 1'b0;
    inHit = 1'b0;
    if (!ativa) return 3'b000;
    for (int k = 0; k < N; k++) begin
      cx = int'(mPos[8*k +: 4]);
      cy = int'(mPos[8*k+4 +: 4]);
      if (cx >= 1 && cx <= 8 && cy >= 1 && cy <= 8) begin
        l = 16 + (cx - 1) * 62;
        t = 16 + (cy - 1) * 57;
        if (x > l && x < l + 54 && y > t && y < t + 49) begin
          inAny = 1'b1;
          if (mHit[k]) inHit = 1'b1;
        end
      end
    end
    if (mAfund && inAny) return 3'b100;
    if (!mVis) return 3'b000;
    if (inHit) return (((mPulses / B) % 2) == 1) ? 3'b100 : 3'b110;
    if (inAny) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic modelAfund();
    int nValid;
    logic ok;
    int cx, cy;
    nValid = 0;
    ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      cx = int'(mPos[8*k +: 4]);
      cy = int'(mPos[8*k+4 +: 4]);
      if (cx >= 1 && cx <= 8 && cy >= 1 && cy <= 8) begin
        nValid++;
        if (!mHit[k]) ok = 1'b0;
      end
    end
    return (nValid > 0) && ok;
  endfunction

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s rgb=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic drivePix(input int x, input int y, input logic ativa);
    @(negedge clk);
    coluna    = x[9:0];
    linha     = y[9:0];
    areaAtiva = ativa;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic checkPixExp(input string name, input int x, input int y,
                             input logic ativa, input logic [2:0] exp);
    drivePix(x, y, ativa);
    check3(name, {rgb_r, rgb_g, rgb_b}, exp);
  endtask

  task automatic checkPix(input string name, input int x, input int y, input logic ativa);
    drivePix(x, y, ativa);
    check3(name, {rgb_r, rgb_g, rgb_b}, expRgb(x, y, ativa));
  endtask

  task automatic pulse(input logic [8*N-1:0] pos, input logic [N-1:0] hit, input logic vis);
    @(negedge clk);
    posicoesEmbarcacao = pos;
    acertos            = hit;
    visivel            = vis;
    frame_start        = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    mPos = pos;
    mHit = hit;
    mVis = vis;
    mPulses++;
    mAfund = modelAfund();
    repeat (3) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mPos = '0;
    mHit = '0;
    mVis = 1'b0;
    mPulses = 0;
    mAfund = 1'b0;
  endtask

  logic [8*N-1:0] shipH;
  logic [8*N-1:0] shipMoved;
  logic [8*N-1:0] rndPos;
  logic [2:0]     oldExp;

  initial begin
    rst = 1'b1;
    areaAtiva = 1'b0;
    coluna = '0;
    linha = '0;
    frame_start = 1'b0;
    posicoesEmbarcacao = '0;
    acertos = '0;
    visivel = 1'b0;
    mPos = '0; mHit = '0; mVis = 1'b0; mPulses = 0; mAfund = 1'b0;

    tbl[0] = '{40, 40, 1'b1, 3'b001};
    tbl[1] = '{16, 40, 1'b1, 3'b000};
    tbl[2] = '{17, 17, 1'b1, 3'b001};
    tbl[3] = '{69, 64, 1'b1, 3'b001};
    tbl[4] = '{70, 40, 1'b1, 3'b000};
    tbl[5] = '{40, 65, 1'b1, 3'b000};
    tbl[6] = '{40, 16, 1'b1, 3'b000};
    tbl[7] = '{40, 40, 1'b0, 3'b000};

    repeat (3) @(negedge clk);
    #1;
    check3("reset_rgb", {rgb_r, rgb_g, rgb_b}, 3'b000);
    checkBit("reset_afundado", afundado, 1'b0);
    rst = 1'b0;

    // Single cell at (1,1); remaining cells invalid.
    pulse({cel(0, 0), cel(0, 0), cel(0, 0), cel(0, 0), cel(1, 1)}, 5'b00000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkPixExp($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].ativa, tbl[i].exp);
    end

    // Horizontal ship X3..7 on row 4.
    shipH = {cel(7, 4), cel(6, 4), cel(5, 4), cel(4, 4), cel(3, 4)};
    pulse(shipH, 5'b00000, 1'b1);
    checkPixExp("row_140", 140, 200, 1'b1, 3'b000);
    checkPixExp("row_141", 141, 200, 1'b1, 3'b001);
    checkPixExp("row_193", 193, 200, 1'b1, 3'b001);
    checkPixExp("row_194", 194, 200, 1'b1, 3'b000);
    checkPixExp("row_202", 202, 200, 1'b1, 3'b000);
    checkPixExp("row_203", 203, 200, 1'b1, 3'b001);
    checkPixExp("row_441", 441, 200, 1'b1, 3'b001);
    checkPixExp("row_442", 442, 200, 1'b1, 3'b000);
    for (int x = 130; x <= 450; x += 3) checkPix($sformatf("scan_%0d", x), x, 200, 1'b1);

    // Blink: known pulse count from reset, middle cell hit.
    doReset();
    for (int f = 0; f < 5; f++) begin
      pulse(shipH, 5'b00100, 1'b1);
      checkPix($sformatf("blink_hit_f%0d", f), 291, 211, 1'b1);
      checkPix($sformatf("blink_free_f%0d", f), 167, 211, 1'b1);
      checkBit($sformatf("blink_afund_f%0d", f), afundado, 1'b0);
    end
    pulse(shipH, 5'b00100, 1'b1);
    checkPixExp("blink_p6_red", 291, 211, 1'b1, 3'b100);
    pulse(shipH, 5'b00100, 1'b1);
    checkPixExp("blink_p7_red", 291, 211, 1'b1, 3'b100);
    pulse(shipH, 5'b00100, 1'b1);
    checkPixExp("blink_p8_yel", 291, 211, 1'b1, 3'b110);

    // Sunk ship, then hidden but still red.
    pulse(shipH, 5'b11111, 1'b1);
    checkBit("sunk_afund", afundado, 1'b1);
    checkPixExp("sunk_c0", 167, 211, 1'b1, 3'b100);
    checkPixExp("sunk_c4", 415, 211, 1'b1, 3'b100);
    pulse(shipH, 5'b11111, 1'b0);
    checkPixExp("sunk_hidden", 291, 211, 1'b1, 3'b100);
    checkPixExp("sunk_gap", 198, 211, 1'b1, 3'b000);
    pulse(shipH, 5'b00000, 1'b0);
    checkBit("unsunk_afund", afundado, 1'b0);
    checkPixExp("hidden_free", 291, 211, 1'b1, 3'b000);

    // Input change without frame_start has no effect until the next pulse.
    pulse(shipH, 5'b00000, 1'b1);
    shipMoved = {cel(2, 8), cel(2, 7), cel(2, 6), cel(2, 5), cel(2, 4)};
    @(negedge clk);
    posicoesEmbarcacao = shipMoved;
    acertos = 5'b11111;
    visivel = 1'b0;
    checkPixExp("mid_old", 167, 211, 1'b1, 3'b001);
    checkPixExp("mid_new_absent", 100, 440, 1'b1, 3'b000);
    checkBit("mid_afund", afundado, 1'b0);
    pulse(shipMoved, 5'b00000, 1'b1);
    checkPixExp("moved_old_gone", 167, 211, 1'b1, 3'b000);
    checkPixExp("moved_new", 100, 440, 1'b1, 3'b001);

    // Pixel coinciding with frame_start renders from the old shadow.
    oldExp = expRgb(100, 440, 1'b1);
    @(negedge clk);
    coluna = 10'd100;
    linha = 10'd440;
    areaAtiva = 1'b1;
    posicoesEmbarcacao = shipH;
    acertos = 5'b11111;
    visivel = 1'b0;
    frame_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    check3("fs_pixel_old", {rgb_r, rgb_g, rgb_b}, oldExp);
    mPos = shipH; mHit = 5'b11111; mVis = 1'b0; mPulses++; mAfund = modelAfund();
    repeat (3) @(negedge clk);
    checkPixExp("fs_after_gone", 100, 440, 1'b1, 3'b000);
    checkPixExp("fs_after_sunk", 167, 211, 1'b1, 3'b100);

    // Invalid cells: never drawn, excluded from sunk.
    pulse({cel(3, 9), cel(6, 2), cel(5, 2), cel(4, 2), cel(3, 2)}, 5'b01111, 1'b1);
    checkBit("inv_afund", afundado, 1'b1);
    checkPixExp("inv_y9", 160, 490, 1'b1, 3'b000);
    pulse({cel(0, 3), cel(6, 2), cel(5, 2), cel(4, 2), cel(3, 2)}, 5'b01111, 1'b1);
    checkBit("inv_x0_afund", afundado, 1'b1);
    checkPixExp("inv_valid_red", 167, 100, 1'b1, 3'b100);
    pulse({cel(0, 3), cel(9, 2), cel(5, 0), cel(12, 2), cel(3, 15)}, 5'b11111, 1'b1);
    checkBit("none_valid_afund", afundado, 1'b0);

    // Reset mid-frame clears outputs immediately and nothing draws afterwards.
    pulse(shipH, 5'b11111, 1'b1);
    checkPixExp("pre_rst_red", 167, 211, 1'b1, 3'b100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check3("rst_mid_rgb", {rgb_r, rgb_g, rgb_b}, 3'b000);
    checkBit("rst_mid_afund", afundado, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mPos = '0; mHit = '0; mVis = 1'b0; mPulses = 0; mAfund = 1'b0;
    checkPixExp("post_rst_blank", 167, 211, 1'b1, 3'b000);
    checkBit("post_rst_afund", afundado, 1'b0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 24; f++) begin
      rndPos = '0;
      for (int k = 0; k < N; k++) begin
        rndPos[8*k +: 8] = cel(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
      end
      if (f % 4 == 0) rndPos = {cel(5, 6), cel(5, 5), cel(5, 4), cel(5, 3), cel(5, 2)};
      pulse(rndPos, N'($urandom), ($urandom_range(0, 3) != 0));
      checkBit($sformatf("rnd_afund_f%0d", f), afundado, mAfund);
      for (int p = 0; p < 25; p++) begin
        int cx, cy, px, py;
        if (p % 2 == 0) begin
          cx = $urandom_range(1, 8);
          cy = $urandom_range(1, 8);
          px = 16 + (cx - 1) * 62 + $urandom_range(0, 56);
          py = 16 + (cy - 1) * 57 + $urandom_range(0, 51);
        end else begin
          px = $urandom_range(0, 639);
          py = $urandom_range(0, 520);
        end
        checkPix($sformatf("rnd_f%0d_p%0d", f, p), px, py, ($urandom_range(0, 7) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
